// File: rtl/hit_pkg.sv
// Shared record layout and pairing-FSM encoding for the hit builder.
package hit_pkg;

  localparam int HIT_W      = 72;
  localparam int T_LSB      = 31;
  localparam int T_W        = 38;
  localparam int Q_W        = 31;
  localparam int FLAG_TMISS = 69;
  localparam int FLAG_QMISS = 70;
  localparam int FLAG_LOST  = 71;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAVE_T = 2'd1,
    HAVE_Q = 2'd2
  } pair_state_e;

  // Assemble a record; the lost flag is filled in later, at the FIFO write.
  function automatic logic [HIT_W-1:0] make_record(input logic [T_W-1:0] t,
                                                   input logic [Q_W-1:0] q,
                                                   input logic           t_miss,
                                                   input logic           q_miss);
    logic [HIT_W-1:0] r;
    r                 = '0;
    r[T_LSB +: T_W]   = t;
    r[Q_W-1:0]        = q;
    r[FLAG_TMISS]     = t_miss;
    r[FLAG_QMISS]     = q_miss;
    return r;
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// The head register keeps its last value when the FIFO drains empty.
module hit_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    rd_next;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = dout_q;

  // Pointer, occupancy and head-word next-state; a full FIFO still accepts a push when it pops.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_next  = rd_ptr_q + PW'(1);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_next           : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    dout_d = dout_q;
    if (do_push && (empty || (do_pop && count_q == CW'(1)))) begin
      dout_d = din;
    end else if (do_pop && count_q > CW'(1)) begin
      dout_d = mem_q[rd_next];
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; occupancy and pointers alone decide which entries are meaningful.
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/hit_builder.sv
// Pairs CFD timestamps with charges into 72-bit hit records and queues them
// in an FWFT FIFO for readout. Unpartnered halves time out as flagged orphans.
module hit_builder
  import hit_pkg::*;
#(
  parameter int MATCH_WINDOW = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        t_valid,
  input  logic [T_W-1:0]              t_in,
  input  logic                        q_valid,
  input  logic [Q_W-1:0]              q_in,
  output logic                        hit_valid,
  input  logic                        hit_ready,
  output logic [HIT_W-1:0]            hit_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]            drop_cnt
);

  localparam int TMR_W = 8;

  pair_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [T_W-1:0]   pend_t_q, pend_t_d;
  logic [Q_W-1:0]   pend_q_q, pend_q_d;
  logic             gen_valid_q, gen_valid_d;
  logic [HIT_W-1:0] gen_rec_q, gen_rec_d;
  logic             lost_q, lost_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             timeout;

  logic             fifo_full, fifo_empty, pop, push_ok;
  logic [HIT_W-1:0] push_rec;

  assign timeout = (timer_q == TMR_W'(MATCH_WINDOW - 1));

  // Pairing FSM next-state: at most one record per cycle, registered before the FIFO write.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    timer_d     = timer_q;
    pend_t_d    = pend_t_q;
    pend_q_d    = pend_q_q;
    gen_valid_d = 1'b0;
    gen_rec_d   = gen_rec_q;
    case (state_q)
      IDLE: begin
        if (t_valid && q_valid) begin
          gen_valid_d = 1'b1;
          gen_rec_d   = make_record(t_in, q_in, 1'b0, 1'b0);
        end else if (t_valid) begin
          pend_t_d = t_in;
          timer_d  = '0;
          state_d  = HAVE_T;
        end else if (q_valid) begin
          pend_q_d = q_in;
          timer_d  = '0;
          state_d  = HAVE_Q;
        end
      end
      HAVE_T: begin
        if (q_valid) begin
          gen_valid_d = 1'b1;
          gen_rec_d   = make_record(pend_t_q, q_in, 1'b0, 1'b0);
          if (t_valid) begin
            pend_t_d = t_in;
            timer_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (t_valid) begin
          gen_valid_d = 1'b1;
          gen_rec_d   = make_record(pend_t_q, '0, 1'b0, 1'b1);
          pend_t_d    = t_in;
          timer_d     = '0;
        end else if (timeout) begin
          gen_valid_d = 1'b1;
          gen_rec_d   = make_record(pend_t_q, '0, 1'b0, 1'b1);
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HAVE_Q: begin
        if (t_valid) begin
          gen_valid_d = 1'b1;
          gen_rec_d   = make_record(t_in, pend_q_q, 1'b0, 1'b0);
          if (q_valid) begin
            pend_q_d = q_in;
            timer_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (q_valid) begin
          gen_valid_d = 1'b1;
          gen_rec_d   = make_record('0, pend_q_q, 1'b1, 1'b0);
          pend_q_d    = q_in;
          timer_d     = '0;
        end else if (timeout) begin
          gen_valid_d = 1'b1;
          gen_rec_d   = make_record('0, pend_q_q, 1'b1, 1'b0);
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO admission: a rejected record bumps the drop counter and marks the next stored one as lost.
  always_comb begin
    pop      = !fifo_empty && hit_ready;
    push_ok  = gen_valid_q && (!fifo_full || pop);
    push_rec = {lost_q, gen_rec_q[HIT_W-2:0]};
    lost_d   = lost_q;
    drop_d   = drop_q;
    if (gen_valid_q) begin
      if (push_ok) begin
        lost_d = 1'b0;
      end else begin
        lost_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
      end
    end
  end

  // Pairing FSM, generated-record register and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      pend_t_q    <= '0;
      pend_q_q    <= '0;
      gen_valid_q <= 1'b0;
      gen_rec_q   <= '0;
      lost_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pend_t_q    <= pend_t_d;
      pend_q_q    <= pend_q_d;
      gen_valid_q <= gen_valid_d;
      gen_rec_q   <= gen_rec_d;
      lost_q      <= lost_d;
      drop_q      <= drop_d;
    end
  end

  hit_fifo #(
    .WIDTH (HIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .din   (push_rec),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (hit_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign hit_valid = !fifo_empty;
  assign drop_cnt  = drop_q;

endmodule
